// File: rtl/basic_computer_pkg.sv
// -----------------------------------------------------------------------------
// basic_computer_pkg
//
// Shared definitions for the basic computer datapath:
//   - ALU operation codes as they appear in the instruction decoder
//   - datapath word widths (WORD_W for AC/memory words, CHAR_W for the
//     character-wide I/O registers)
//   - small helpers used where a word is narrowed to a character
//
// No ports (package).
// -----------------------------------------------------------------------------
package basic_computer_pkg;

    localparam int WORD_W = 16;
    localparam int CHAR_W = 8;

    // ALU operation codes. The codes the ALU does not implement are not
    // listed here and decode to "no operation" in the ALU.
    typedef enum logic [3:0] {
        ALU_AND = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_LDA = 4'b0011,
        ALU_CMA = 4'b1001,
        ALU_CME = 4'b1010,
        ALU_CIR = 4'b1011,
        ALU_CIL = 4'b1100,
        ALU_INP = 4'b1101
    } alu_op_t;

    // Low character of a datapath word; this is what OUT sends to OUTR.
    function automatic logic [CHAR_W-1:0] char_of(input logic [WORD_W-1:0] word);
        return word[CHAR_W-1:0];
    endfunction

endpackage : basic_computer_pkg

// File: rtl/accumulator_unit_outr_port.sv
// -----------------------------------------------------------------------------
// outr_port
//
// Character output register (OUTR) with its FGO ready-flag handshake and a
// sticky overrun flag.
//
//   fgo = 1 : OUTR is free, the next OUT is accepted.
//   fgo = 0 : the device still owns OUTR; an OUT is rejected and recorded
//             in outr_ovr, which only reset clears.
//
// Ports:
//   clk           in   1       system clock, rising edge
//   rst           in   1       asynchronous, active-high reset
//   outr_ld       in   1       OUT instruction strobe
//   out_ack       in   1       device has consumed OUTR
//   char_in       in   CHAR_W  character to capture (AC low byte, pre-update)
//   outr_outdata  out  CHAR_W  OUTR contents
//   fgo           out  1       OUTR free flag
//   outr_ovr      out  1       sticky overrun flag
// -----------------------------------------------------------------------------
module outr_port
    import basic_computer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              outr_ld,
    input  logic              out_ack,
    input  logic [CHAR_W-1:0] char_in,
    output logic [CHAR_W-1:0] outr_outdata,
    output logic              fgo,
    output logic              outr_ovr
);

    logic [CHAR_W-1:0] outr_q;
    logic              fgo_q;
    logic              ovr_q;

    logic              ld_accept;
    logic              ld_reject;
    logic              ack_take;

    // A load only succeeds against a free register. An ack only matters
    // while the device owns the register; with a simultaneous load and
    // ack on a busy register the ack frees it, but the load that arrived
    // on the same edge was still issued against a busy register and is
    // rejected.
    always_comb begin
        ld_accept = outr_ld &&  fgo_q;
        ld_reject = outr_ld && !fgo_q;
        ack_take  = out_ack && !fgo_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outr_q <= '0;
            fgo_q  <= 1'b1;
            ovr_q  <= 1'b0;
        end else begin
            if (ld_accept) begin
                outr_q <= char_in;
                fgo_q  <= 1'b0;
            end else if (ack_take) begin
                fgo_q  <= 1'b1;
            end
            if (ld_reject) begin
                ovr_q  <= 1'b1;
            end
        end
    end

    assign outr_outdata = outr_q;
    assign fgo          = fgo_q;
    assign outr_ovr     = ovr_q;

endmodule : outr_port

// File: rtl/accumulator_unit.sv
// -----------------------------------------------------------------------------
// accumulator_unit
//
// Accumulator (AC) and E carry flip-flop of the basic computer, plus the
// register-reference micro-operations that bypass the ALU (CLA, INC, CLE),
// the skip-condition flags, and the character output register.
//
// AC next value, highest priority first: clear, load from ALU, increment,
// hold. E next value: clear, load from ALU, hold. AC and E are independent,
// so ADD/CIR/CIL update both on one edge.
//
// Build option:
//   ACCUM_OUTR_EN  defined   -> OUTR/FGO handshake (outr_port) is built.
//                  undefined -> outr_outdata=0, fgo=1, outr_ovr=0 constant;
//                               outr_ld/out_ack are ignored.
//
// Ports:
//   clk           in   1   system clock, rising edge
//   rst           in   1   asynchronous, active-high reset
//   alu_outdata   in   16  ALU result
//   e_indata      in   1   ALU next-E value
//   ff_en         in   1   load E from e_indata
//   ac_ld         in   1   load AC from alu_outdata
//   ac_clr        in   1   clear AC
//   ac_inr        in   1   increment AC (mod 2^16, E untouched)
//   e_clr         in   1   clear E
//   outr_ld       in   1   OUT: copy AC[7:0] into OUTR
//   out_ack       in   1   device consumed OUTR
//   ac_outdata    out  16  AC contents
//   e_outdata     out  1   E contents
//   ac_zero       out  1   AC == 0
//   ac_neg        out  1   AC[15]
//   ac_pos        out  1   AC[15] == 0 and AC != 0
//   e_zero        out  1   E == 0
//   outr_outdata  out  8   OUTR contents
//   fgo           out  1   OUTR free flag
//   outr_ovr      out  1   sticky OUTR overrun
// -----------------------------------------------------------------------------
module accumulator_unit
    import basic_computer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] alu_outdata,
    input  logic              e_indata,
    input  logic              ff_en,
    input  logic              ac_ld,
    input  logic              ac_clr,
    input  logic              ac_inr,
    input  logic              e_clr,
    input  logic              outr_ld,
    input  logic              out_ack,
    output logic [WORD_W-1:0] ac_outdata,
    output logic              e_outdata,
    output logic              ac_zero,
    output logic              ac_neg,
    output logic              ac_pos,
    output logic              e_zero,
    output logic [CHAR_W-1:0] outr_outdata,
    output logic              fgo,
    output logic              outr_ovr
);

    logic [WORD_W-1:0] ac_q;
    logic              e_q;
    logic [WORD_W-1:0] ac_d;
    logic              e_d;

    // INC wraps: 0xFFFF + 1 = 0x0000 with the carry discarded, so E is
    // never disturbed by INC.
    function automatic logic [WORD_W-1:0] inc_wrap(input logic [WORD_W-1:0] v);
        return v + WORD_W'(1);
    endfunction

    always_comb begin
        ac_d = ac_q;
        if (ac_clr) begin
            ac_d = '0;
        end else if (ac_ld) begin
            ac_d = alu_outdata;
        end else if (ac_inr) begin
            ac_d = inc_wrap(ac_q);
        end
    end

    always_comb begin
        e_d = e_q;
        if (e_clr) begin
            e_d = 1'b0;
        end else if (ff_en) begin
            e_d = e_indata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ac_q <= '0;
            e_q  <= 1'b0;
        end else begin
            ac_q <= ac_d;
            e_q  <= e_d;
        end
    end

    // Skip-condition flags straight off the registers: a test issued the
    // cycle after an update already sees the new value.
    always_comb begin
        ac_zero = (ac_q == '0);
        ac_neg  = ac_q[WORD_W-1];
        ac_pos  = !ac_q[WORD_W-1] && (ac_q != '0);
        e_zero  = !e_q;
    end

    assign ac_outdata = ac_q;
    assign e_outdata  = e_q;

`ifdef ACCUM_OUTR_EN
    // OUTR is fed from the registered AC, i.e. the value before any AC
    // update happening on the same edge.
    outr_port u_outr_port (
        .clk          (clk),
        .rst          (rst),
        .outr_ld      (outr_ld),
        .out_ack      (out_ack),
        .char_in      (char_of(ac_q)),
        .outr_outdata (outr_outdata),
        .fgo          (fgo),
        .outr_ovr     (outr_ovr)
    );
`else
    // Output port absent: the device always sees a free, empty register.
    logic unused_outr_ctl;
    assign unused_outr_ctl = outr_ld ^ out_ack;

    assign outr_outdata = '0;
    assign fgo          = 1'b1;
    assign outr_ovr     = 1'b0;
`endif

endmodule : accumulator_unit

// File: tb/tb_accumulator_unit.sv
// -----------------------------------------------------------------------------
// tb_accumulator_unit
//
// Directed bench for accumulator_unit. A behavioural model (plain integers)
// tracks AC, E and the output port; one process compares every DUT output
// against it on each falling edge, and hand-computed literals pin the model
// at key points. Works for builds with and without ACCUM_OUTR_EN.
// -----------------------------------------------------------------------------
module tb_accumulator_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] alu_outdata;
    logic        e_indata, ff_en, ac_ld, ac_clr, ac_inr, e_clr, outr_ld, out_ack;
    logic [15:0] ac_outdata;
    logic        e_outdata, ac_zero, ac_neg, ac_pos, e_zero;
    logic [7:0]  outr_outdata;
    logic        fgo, outr_ovr;

    accumulator_unit dut (
        .clk          (clk),
        .rst          (rst),
        .alu_outdata  (alu_outdata),
        .e_indata     (e_indata),
        .ff_en        (ff_en),
        .ac_ld        (ac_ld),
        .ac_clr       (ac_clr),
        .ac_inr       (ac_inr),
        .e_clr        (e_clr),
        .outr_ld      (outr_ld),
        .out_ack      (out_ack),
        .ac_outdata   (ac_outdata),
        .e_outdata    (e_outdata),
        .ac_zero      (ac_zero),
        .ac_neg       (ac_neg),
        .ac_pos       (ac_pos),
        .e_zero       (e_zero),
        .outr_outdata (outr_outdata),
        .fgo          (fgo),
        .outr_ovr     (outr_ovr)
    );

    always #5 clk = ~clk;

`ifdef ACCUM_OUTR_EN
    localparam bit OUTR_EN = 1'b1;
`else
    localparam bit OUTR_EN = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model state
    int m_ac, m_e, m_outr, m_fgo, m_ovr;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ac = 0; m_e = 0; m_outr = 0; m_fgo = 1; m_ovr = 0;
    endtask

    // Apply one cycle of commands, let the edge happen, advance the model.
    task automatic step(input logic [15:0] alu, input bit ld, input bit clr, input bit inr,
                        input bit ffen, input bit ein, input bit eclr,
                        input bit old, input bit ack);
        int ac_before;
        alu_outdata = alu; ac_ld = ld; ac_clr = clr; ac_inr = inr;
        ff_en = ffen; e_indata = ein; e_clr = eclr; outr_ld = old; out_ack = ack;
        @(posedge clk);
        ac_before = m_ac;
        if (clr)      m_ac = 0;
        else if (ld)  m_ac = int'(alu);
        else if (inr) m_ac = (m_ac + 1) % 65536;
        if (eclr)      m_e = 0;
        else if (ffen) m_e = int'(ein);
        if (OUTR_EN) begin
            if (old && m_fgo == 1) begin
                m_outr = ac_before % 256;
                m_fgo  = 0;
            end else begin
                if (ack) m_fgo = 1;
                if (old) m_ovr = 1;
            end
        end
        #1;
        ac_ld = 0; ac_clr = 0; ac_inr = 0; ff_en = 0; e_indata = 0;
        e_clr = 0; outr_ld = 0; out_ack = 0; alu_outdata = 16'h0;
    endtask

    // Compare process: every falling edge while checking is enabled.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ac",      int'(ac_outdata),   m_ac);
            check("e",       int'(e_outdata),    m_e);
            check("ac_zero", int'(ac_zero),      int'(m_ac == 0));
            check("ac_neg",  int'(ac_neg),       int'(m_ac >= 32768));
            check("ac_pos",  int'(ac_pos),       int'(m_ac > 0 && m_ac < 32768));
            check("e_zero",  int'(e_zero),       int'(m_e == 0));
            check("outr",    int'(outr_outdata), m_outr);
            check("fgo",     int'(fgo),          m_fgo);
            check("ovr",     int'(outr_ovr),     m_ovr);
        end
    end

    initial begin
        rst = 1'b1;
        alu_outdata = 16'h0; e_indata = 0; ff_en = 0; ac_ld = 0; ac_clr = 0;
        ac_inr = 0; e_clr = 0; outr_ld = 0; out_ack = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        // Reset state
        check("rst_ac",   int'(ac_outdata), 0);
        check("rst_e",    int'(e_outdata), 0);
        check("rst_fgo",  int'(fgo), 1);
        check("rst_zero", int'(ac_zero), 1);
        check("rst_ez",   int'(e_zero), 1);
        check("rst_pos",  int'(ac_pos), 0);
        check("rst_outr", int'(outr_outdata), 0);
        check("rst_ovr",  int'(outr_ovr), 0);

        // ADD-style: AC and E together
        step(16'h8001, 1, 0, 0, 1, 1, 0, 0, 0);
        check("ld_ac",  int'(ac_outdata), 'h8001);
        check("ld_e",   int'(e_outdata), 1);
        check("ld_neg", int'(ac_neg), 1);
        check("ld_pos", int'(ac_pos), 0);
        check("mdl_ac", m_ac, 'h8001);

        // INC wraps, E untouched
        step(16'hFFFF, 1, 0, 0, 0, 0, 0, 0, 0);
        step(16'h0000, 0, 0, 1, 0, 0, 0, 0, 0);
        check("inc_wrap", int'(ac_outdata), 0);
        check("inc_e",    int'(e_outdata), 1);
        check("inc_zero", int'(ac_zero), 1);

        // Clear beats load; load beats increment
        step(16'h1234, 1, 0, 0, 0, 0, 0, 0, 0);
        step(16'h5555, 1, 1, 0, 0, 0, 0, 0, 0);
        check("clr_ld", int'(ac_outdata), 0);
        step(16'h0010, 1, 0, 1, 0, 0, 0, 0, 0);
        check("ld_inr", int'(ac_outdata), 'h0010);
        step(16'h0000, 0, 0, 1, 0, 0, 0, 0, 0);
        check("inr", int'(ac_outdata), 'h0011);
        check("inr_pos", int'(ac_pos), 1);

        // E: clear beats load, then load, then hold, then load 0
        step(16'h0000, 0, 0, 0, 1, 1, 1, 0, 0);
        check("eclr_ff", int'(e_outdata), 0);
        step(16'h0000, 0, 0, 0, 1, 1, 0, 0, 0);
        check("eld",     int'(e_outdata), 1);
        check("eld_ez",  int'(e_zero), 0);
        step(16'h0000, 0, 0, 0, 0, 1, 0, 0, 0);
        check("ehold",   int'(e_outdata), 1);
        step(16'h0000, 0, 0, 0, 1, 0, 0, 0, 0);
        check("eld0",    int'(e_outdata), 0);

        // Output handshake
        step(16'h00A5, 1, 0, 0, 0, 0, 0, 0, 0);
        step(16'h0000, 0, 0, 0, 0, 0, 0, 1, 0);
        check("out1",   int'(outr_outdata), OUTR_EN ? 'hA5 : 0);
        check("out1_f", int'(fgo), OUTR_EN ? 0 : 1);
        step(16'h003C, 1, 0, 0, 0, 0, 0, 0, 0);
        step(16'h0000, 0, 0, 0, 0, 0, 0, 1, 0);
        check("out2",   int'(outr_outdata), OUTR_EN ? 'hA5 : 0);
        check("ovr",    int'(outr_ovr), OUTR_EN ? 1 : 0);
        step(16'h0000, 0, 0, 0, 0, 0, 0, 0, 1);
        check("ack",    int'(fgo), 1);
        step(16'h0000, 0, 0, 0, 0, 0, 0, 0, 1);
        check("ack_idle", int'(fgo), 1);
        // OUT with same-edge AC load captures the old AC (0x3C)
        step(16'h0077, 1, 0, 0, 0, 0, 0, 1, 0);
        check("out_old", int'(outr_outdata), OUTR_EN ? 'h3C : 0);
        check("out_ac",  int'(ac_outdata), 'h0077);
        // Busy: ack + load -> ack frees, load rejected
        step(16'h0000, 0, 0, 0, 0, 0, 0, 1, 1);
        check("busy_both_f", int'(fgo), 1);
        check("busy_both_o", int'(outr_outdata), OUTR_EN ? 'h3C : 0);
        // Free: ack + load -> load accepted
        step(16'h0000, 0, 0, 0, 0, 0, 0, 1, 1);
        check("free_both_f", int'(fgo), OUTR_EN ? 0 : 1);
        check("free_both_o", int'(outr_outdata), OUTR_EN ? 'h77 : 0);
        check("mdl_outr",    m_outr, OUTR_EN ? 'h77 : 0);
        // Disabled-build case: AC=0xFF, OUT has no effect
        step(16'h00FF, 1, 0, 0, 1, 1, 0, 0, 0);
        step(16'h0000, 0, 0, 0, 0, 0, 0, 1, 0);
        check("ff_out",  int'(outr_outdata), OUTR_EN ? 'h77 : 0);
        check("ff_ovr",  int'(outr_ovr), OUTR_EN ? 1 : 0);

        // Reset in the middle of a pending load of 0x1234
        @(negedge clk);
        alu_outdata = 16'h1234; ac_ld = 1;
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("arst_ac", int'(ac_outdata), 0);
        @(posedge clk);
        #1 rst = 1'b0; ac_ld = 0; alu_outdata = 16'h0;
        check("mrst_ac",  int'(ac_outdata), 0);
        check("mrst_e",   int'(e_outdata), 0);
        check("mrst_fgo", int'(fgo), 1);
        check("mrst_ovr", int'(outr_ovr), 0);
        check("mrst_out", int'(outr_outdata), 0);
        step(16'h0000, 0, 0, 0, 0, 0, 0, 0, 0);
        check("post_rst", int'(ac_outdata), 0);

        @(negedge clk);
        #1 chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_accumulator_unit
